// File: rtl/mem_resp_pkg.sv
// Shared types, constants and address checks for the multi-cycle data-memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Flags an access as bad: either not word aligned, or above the last stored word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] hi;
        hi = addr >> (2 + idx_w);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: synchronous byte-enable write, registered read, no reset on contents.
module mem_word_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and a read register that holds its value between reads.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: captures one request, stalls the pipeline for a fixed
// latency, then acks for one cycle with read data and an error flag.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
    localparam bit          LAT1  = (LATENCY == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             rzero_q, rzero_d;

    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_err;
    logic             enter_resp;
    logic             arr_we;
    logic             arr_re;
    logic [31:0]      arr_rdata;

    // With LATENCY=1 the array is accessed on the capture edge, so it sees the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            acc_be    = be_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_err    = addr_err(acc_addr, IDX_W);
        // Gated by reset so an access in flight never touches the array while reset is low.
        enter_resp = rst_i && (((state_q == S_IDLE) && req_i && LAT1) ||
                               ((state_q == S_WAIT) && (cnt_q == '0)));
        arr_we     = enter_resp && acc_we && !acc_err;
        arr_re     = enter_resp && !acc_we && !acc_err;
    end

    // Next-state logic for the FSM, wait counter and request capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rzero_d = rzero_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    if (LAT1) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A failed load shows zero data; a good load shows the array word.
        if (enter_resp && !acc_we) begin
            rzero_d = acc_err;
        end
    end

    // State and capture registers; reset aborts any access in progress.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rzero_q <= rzero_d;
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .be_i    (acc_be),
        .re_i    (arr_re),
        .idx_i   (acc_addr[2 +: IDX_W]),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    // Outputs: Mealy stall, one-cycle ack, error from the captured address.
    always_comb begin
        stall_o = rst_i && (((state_q == S_IDLE) && req_i) || (state_q == S_WAIT));
        ack_o   = (state_q == S_RESP);
        err_o   = (state_q == S_RESP) && addr_err(addr_q, IDX_W);
        rdata_o = rzero_q ? 32'd0 : arr_rdata;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage load/store port and replaces the single-cycle data memory. It accepts one word request at a time and holds the pipeline through a stall signal until the access completes. It services the request after a fixed, parameterised latency and returns a one-cycle acknowledge together with read data and an error flag. This block is the foundation for the upcoming off-chip memory and cache work.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two.
LATENCY, 10, cycles from the first request cycle to the ack cycle; minimum 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
req_i  in  1  MEM stage has a load or store this cycle; held stable by the pipeline while stall_o=1.
we_i  in  1  1=store, 0=load.
addr_i  in  32  byte address.
wdata_i  in  32  store data.
be_i  in  4  byte enables for stores; be_i[0] selects bits 7:0.
stall_o  out  1  pipeline must freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
ack_o  out  1  access completes this cycle.
rdata_o  out  32  load data; valid while ack_o=1 and held until the next load ack.
err_o  out  1  completing access was misaligned or out of range; valid while ack_o=1.

Behaviour:
- FSM states:
  - IDLE.
  - WAIT: counter cnt, width clog2(LATENCY)+1.
  - RESP: one cycle.
- IDLE with req_i=1 (cycle T):
  - Capture we, addr, wdata and be on the clock edge.
  - If LATENCY=1, go to RESP. Otherwise load cnt=LATENCY-2 and go to WAIT.
- WAIT:
  - If cnt=0, go to RESP; otherwise decrement cnt.
  - Input changes during WAIT are ignored; the captured copy is used.
- RESP:
  - ack_o=1, stall_o=0; the pipeline advances in this cycle.
  - Next state is always IDLE. req_i seen during RESP belongs to the completing access and is ignored.
- Ack timing: ack_o rises at cycle T+LATENCY.
- stall_o (combinational, Mealy):
  - stall_o = (IDLE & req_i) | WAIT.
  - It is high for exactly LATENCY cycles per access.
- Array effects, all on the edge that enters RESP:
  - Store: bytes with be=1 are written. be=0000 completes as a no-op ack.
  - Load: rdata_o is registered from the array as the full word; be is ignored.
- Index: addr[2 +: clog2(DEPTH_WORDS)].
- Error cases:
  - Out of range: addr[31:2+clog2(DEPTH_WORDS)] is not 0.
  - Misaligned: addr[1:0] is not 0.
  - On error: no write; rdata_o=0 for loads; err_o=1 in RESP; latency is unchanged.
- Back-to-back accesses: a request presented in the cycle after RESP is a new access, accepted from IDLE. Minimum issue interval is LATENCY+1 cycles.
- Reset values (rst_i=0): state IDLE, cnt=0, ack_o=0, err_o=0, rdata_o=0, stall_o=0 (it follows req_i once reset is released).
- Reset mid-operation aborts the access: no write and no ack. Array contents are not reset; the bench preloads them.
- Clock gating: none.
- Counter range: cnt never wraps; it is bounded by LATENCY.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {S_IDLE, S_WAIT, S_RESP};
  - constant WORD_BYTES=4;
  - function for the range/alignment check.
- Sub-module mem_word_array:
  - synchronous byte-enable write port;
  - registered read;
  - DEPTH_WORDS parameter;
  - no reset.
- The FSM, counter and capture registers stay in data_mem_responder.

Test Plan:
- LATENCY=10, preload word 4 = 0xDEADBEEF; load addr 0x10 at T -> stall_o high T..T+9, ack_o=1 and rdata_o=0xDEADBEEF at T+10, err_o=0, stall_o=0 at T+10.
- Store 0x12345678 to addr 0x20 with be=0101, word preloaded with 0xAAAAAAAA, then load 0x20 -> rdata_o=0xAA34AA78; the second ack arrives 11 cycles after the first.
- Misaligned load addr 0x22, and out-of-range store to addr 0x1000 with DEPTH_WORDS=1024 -> ack at T+10, err_o=1, rdata_o=0, no array word changes.
- LATENCY=1: back-to-back loads of 0x0 and 0x4 -> stall_o high in the single request cycle only; acks two cycles apart; correct data on each ack.
- Change addr_i and wdata_i to garbage during WAIT of a store to 0x8 -> only word 2 is written, with the originally captured data.
- Assert rst_i=0 at T+5 of a store to 0xC -> no ack, word 3 unchanged, stall_o low during reset, state returns to IDLE.
